// File: rtl/bram_portb_arbiter.sv
// BRAM port B arbiter: VGA pixel reads (priority) share the port with aux read/write traffic.
// Two-stage issue pipeline; an owner tag steers returning read data to the right requester.
module bram_portb_arbiter #(
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_gnt,
  output logic                  vga_rvalid,
  output logic [WIDTH-1:0]      vga_rdata,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [WIDTH-1:0]      aux_wdata,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [WIDTH-1:0]      aux_rdata,
  output logic                  aux_err,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [WIDTH-1:0]      bram_wdata,
  output logic                  bram_we,
  input  logic [WIDTH-1:0]      bram_q
);

  // tag  | meaning
  // NONE | no read in flight in this pipeline slot
  // VGA  | read issued on behalf of VGA
  // AUX  | read issued on behalf of aux
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGA  = 2'd1;
  localparam logic [1:0] TAG_AUX  = 2'd2;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt;
  logic [1:0] tag1;
  logic       force_aux;
  logic       vga_hs;
  logic       aux_hs;
  logic       aux_io;
  logic       aux_wr_drop;

  assign force_aux = (wait_cnt >= STARVE_LIM);

  always_comb begin
    vga_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (!reset) begin
      if (force_aux && aux_req) aux_gnt = 1'b1;
      else if (vga_req)         vga_gnt = 1'b1;
      else if (aux_req)         aux_gnt = 1'b1;
    end
  end

  assign vga_hs      = vga_req & vga_gnt;
  assign aux_hs      = aux_req & aux_gnt;
  assign aux_io      = aux_addr[ADDR_WIDTH-1] & aux_addr[ADDR_WIDTH-2];
  assign aux_wr_drop = aux_hs & aux_we & aux_io;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (!aux_req || aux_hs) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Issue stage; bram_addr deliberately holds its last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_we    <= 1'b0;
      tag1       <= TAG_NONE;
      aux_err    <= 1'b0;
    end else begin
      aux_err <= aux_wr_drop;
      if (vga_hs) begin
        bram_addr <= vga_addr;
        bram_we   <= 1'b0;
        tag1      <= TAG_VGA;
      end else if (aux_hs) begin
        bram_addr  <= aux_addr;
        bram_wdata <= aux_wdata;
        bram_we    <= aux_we & ~aux_io;
        tag1       <= aux_we ? TAG_NONE : TAG_AUX;
      end else begin
        bram_we <= 1'b0;
        tag1    <= TAG_NONE;
      end
    end
  end

  // Return stage: BRAM has sampled on the intervening negedge, so bram_q is valid here.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      vga_rdata  <= '0;
      aux_rdata  <= '0;
    end else begin
      vga_rvalid <= (tag1 == TAG_VGA);
      aux_rvalid <= (tag1 == TAG_AUX);
      if (tag1 == TAG_VGA) vga_rdata <= bram_q;
      if (tag1 == TAG_AUX) aux_rdata <= bram_q;
    end
  end

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench for bram_portb_arbiter with a negedge-clocked BRAM model on port B.
module tb_bram_portb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req;
  logic [9:0]  vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [15:0] vga_rdata;
  logic        aux_req;
  logic        aux_we;
  logic [9:0]  aux_addr;
  logic [15:0] aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [15:0] aux_rdata;
  logic        aux_err;
  logic [9:0]  bram_addr;
  logic [15:0] bram_wdata;
  logic        bram_we;
  logic [15:0] bram_q = 16'h0;

  int vectors = 0;
  int miscompares = 0;

  bram_portb_arbiter #(.WIDTH(16), .ADDR_WIDTH(10), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata), .aux_err(aux_err),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we), .bram_q(bram_q)
  );

  always #10 clk = ~clk;

  // Memory model: untouched words read as a fixed function of the address.
  logic [15:0]   mem [0:1023];
  logic [1023:0] written = '0;

  function automatic logic [15:0] init_val(input logic [9:0] a);
    return (a == 10'h010) ? 16'hBEEF : {6'h2A, a};
  endfunction

  always @(negedge clk) begin
    bram_q <= written[bram_addr] ? mem[bram_addr] : init_val(bram_addr);
    if (bram_we) begin
      mem[bram_addr]     <= bram_wdata;
      written[bram_addr] <= 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] who [0:29];
  logic [9:0] adr [0:29];
  logic       exp_aux;
  logic [9:0] vcnt;
  logic [9:0] acnt;

  initial begin
    reset = 1'b1; vga_req = 1'b0; vga_addr = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    cyc(); cyc();

    // 1: reset state, then a single VGA read
    vga_req = 1'b1; vga_addr = 10'h010;
    #1;
    chk("rst_vga_gnt", 16'(vga_gnt), 16'h0);
    chk("rst_bram_we", 16'(bram_we), 16'h0);
    chk("rst_bram_addr", 16'(bram_addr), 16'h0);
    chk("rst_vga_rvalid", 16'(vga_rvalid), 16'h0);
    chk("rst_aux_rvalid", 16'(aux_rvalid), 16'h0);
    chk("rst_vga_rdata", vga_rdata, 16'h0);
    chk("rst_aux_err", 16'(aux_err), 16'h0);
    cyc();
    reset = 1'b0;
    #1;
    chk("t1_vga_gnt", 16'(vga_gnt), 16'h1);
    chk("t1_aux_gnt", 16'(aux_gnt), 16'h0);
    cyc();
    vga_req = 1'b0;
    #1;
    chk("t1_bram_addr", 16'(bram_addr), 16'h010);
    chk("t1_rvalid_n1", 16'(vga_rvalid), 16'h0);
    cyc();
    #1;
    chk("t1_rvalid_n2", 16'(vga_rvalid), 16'h1);
    chk("t1_rdata", vga_rdata, 16'hBEEF);
    chk("t1_aux_rvalid", 16'(aux_rvalid), 16'h0);
    cyc();
    #1;
    chk("t1_rvalid_n3", 16'(vga_rvalid), 16'h0);
    chk("t1_rdata_hold", vga_rdata, 16'hBEEF);

    // 2: aux write then back-to-back aux read of the same word
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 10'h020; aux_wdata = 16'h1234;
    #1;
    chk("t2_wr_gnt", 16'(aux_gnt), 16'h1);
    cyc();
    aux_we = 1'b0;
    #1;
    chk("t2_bram_we", 16'(bram_we), 16'h1);
    chk("t2_bram_addr", 16'(bram_addr), 16'h020);
    chk("t2_bram_wdata", bram_wdata, 16'h1234);
    chk("t2_rd_gnt", 16'(aux_gnt), 16'h1);
    cyc();
    aux_req = 1'b0;
    #1;
    chk("t2_we_off", 16'(bram_we), 16'h0);
    chk("t2_no_wr_rvalid", 16'(aux_rvalid), 16'h0);
    cyc();
    #1;
    chk("t2_rvalid", 16'(aux_rvalid), 16'h1);
    chk("t2_rdata", aux_rdata, 16'h1234);
    chk("t2_vga_rvalid", 16'(vga_rvalid), 16'h0);
    cyc();
    #1;
    chk("t2_rvalid_off", 16'(aux_rvalid), 16'h0);

    // 3: both requesting continuously -> 8 VGA grants, 1 aux, repeating
    vcnt = '0; acnt = '0;
    for (int i = 0; i < 30; i++) begin
      vga_req = (i < 27); aux_req = (i < 27); aux_we = 1'b0;
      vga_addr = 10'h100 + vcnt; aux_addr = 10'h200 + acnt;
      #1;
      if (i < 27) begin
        exp_aux = (i % 9 == 8);
        chk($sformatf("t3_vga_gnt_%0d", i), 16'(vga_gnt), 16'(!exp_aux));
        chk($sformatf("t3_aux_gnt_%0d", i), 16'(aux_gnt), 16'(exp_aux));
        who[i] = exp_aux ? 2'd2 : 2'd1;
        adr[i] = exp_aux ? (10'h200 + acnt) : (10'h100 + vcnt);
        if (exp_aux) acnt = acnt + 10'd1;
        else vcnt = vcnt + 10'd1;
      end
      if (i >= 2) begin
        chk($sformatf("t3_vga_rvalid_%0d", i), 16'(vga_rvalid), 16'(who[i-2] == 2'd1));
        chk($sformatf("t3_aux_rvalid_%0d", i), 16'(aux_rvalid), 16'(who[i-2] == 2'd2));
        if (who[i-2] == 2'd1) chk($sformatf("t3_vga_rdata_%0d", i), vga_rdata, init_val(adr[i-2]));
        if (who[i-2] == 2'd2) chk($sformatf("t3_aux_rdata_%0d", i), aux_rdata, init_val(adr[i-2]));
      end
      if (i >= 27) who[i] = 2'd0;
      cyc();
    end

    // 4: aux write into I/O region is dropped and flagged
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 10'h3F0; aux_wdata = 16'hAAAA;
    #1;
    chk("t4_gnt", 16'(aux_gnt), 16'h1);
    cyc();
    aux_req = 1'b0; aux_we = 1'b0;
    #1;
    chk("t4_bram_we", 16'(bram_we), 16'h0);
    chk("t4_err", 16'(aux_err), 16'h1);
    cyc();
    #1;
    chk("t4_err_off", 16'(aux_err), 16'h0);
    aux_req = 1'b1;
    #1;
    chk("t4_rd_gnt", 16'(aux_gnt), 16'h1);
    cyc();
    aux_req = 1'b0;
    cyc();
    #1;
    chk("t4_rd_rvalid", 16'(aux_rvalid), 16'h1);
    chk("t4_rd_data", aux_rdata, init_val(10'h3F0));
    cyc();

    // 5: reset right after a VGA handshake, with the wait counter partly run up
    for (int i = 0; i < 5; i++) begin
      vga_req = 1'b1; aux_req = 1'b1; aux_we = 1'b0;
      vga_addr = (i == 4) ? 10'h010 : 10'h140; aux_addr = 10'h240;
      cyc();
    end
    reset = 1'b1;
    #1;
    chk("t5_vga_gnt_rst", 16'(vga_gnt), 16'h0);
    chk("t5_aux_gnt_rst", 16'(aux_gnt), 16'h0);
    cyc();
    reset = 1'b0;
    #1;
    chk("t5_vga_rvalid", 16'(vga_rvalid), 16'h0);
    chk("t5_bram_addr", 16'(bram_addr), 16'h0);
    chk("t5_bram_we", 16'(bram_we), 16'h0);
    chk("t5_vga_rdata", vga_rdata, 16'h0);
    for (int i = 0; i < 9; i++) begin
      vga_addr = 10'h150; aux_addr = 10'h250;
      #1;
      chk($sformatf("t5_vga_gnt_%0d", i), 16'(vga_gnt), 16'(i != 8));
      chk($sformatf("t5_aux_gnt_%0d", i), 16'(aux_gnt), 16'(i == 8));
      if (i == 1) chk("t5_no_late_rvalid", 16'(vga_rvalid), 16'h0);
      cyc();
    end
    vga_req = 1'b0; aux_req = 1'b0;
    cyc(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
